// File: rtl/spi_frame_rx.sv
// ----------------------------------------------------------------------------
// spi_frame_rx
//   SPI mode-0 slave front end running entirely on the system clock. The raw
//   SCLK/MOSI/SS pins are synchronized, edge-detected, and used to assemble one
//   MSB-first frame of FRAME_BITS bits. A good frame is published on o_bits_out
//   with a one-cycle o_frame_valid strobe; a frame with the wrong bit count
//   raises a one-cycle o_frame_err and leaves o_bits_out alone. During the same
//   frame, the response word captured at SS assertion is shifted out on o_miso.
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   rst            synchronous active-high reset
//   i_sclk         SPI clock pin (asynchronous, CPOL=0/CPHA=0)
//   i_mosi         SPI data in, sampled on SCLK rising edge
//   i_ss           SPI slave select, active low
//   i_tx_data      response word, captured when the frame starts
//   o_miso         SPI data out, updated after SCLK falling edge, 0 when idle
//   o_bits_out     last good frame, held until the next good frame
//   o_frame_valid  one-cycle pulse when o_bits_out updates
//   o_frame_err    one-cycle pulse on a frame with the wrong bit count
//   o_busy         high while a frame is in progress
// ----------------------------------------------------------------------------
module spi_frame_rx #(
  parameter int unsigned FRAME_BITS  = 10,
  parameter int unsigned TX_BITS     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  input  logic [TX_BITS-1:0]    i_tx_data,
  output logic                  o_miso,
  output logic [FRAME_BITS-1:0] o_bits_out,
  output logic                  o_frame_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int unsigned CNT_W   = $clog2(FRAME_BITS + 2);
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]   CNT_OVR    = CNT_W'(FRAME_BITS + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronizers, history flops and registered edge pulses
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_mosi_d;
  logic                   r_ss_d;
  logic                   r_sclk_rise;
  logic                   r_sclk_fall;
  logic                   r_ss_rise;
  logic                   r_ss_fall;
  logic [FLUSH_W-1:0]     r_flush_cnt;
  logic                   r_armed;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ss_s;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];

  // Sync chain plus edge detect. r_mosi_d is captured on the same edge as the
  // registered SCLK rise, so it is the MOSI level that accompanied that rise.
  // r_armed blocks SS falls until SS has been seen high from real pin samples
  // after reset, which discards a frame that was already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_mosi_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_ss_rise   <= 1'b0;
      r_ss_fall   <= 1'b0;
      r_flush_cnt <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
      r_sclk_d    <= w_sclk_s;
      r_mosi_d    <= w_mosi_s;
      r_ss_d      <= w_ss_s;
      r_sclk_rise <= w_sclk_s & ~r_sclk_d;
      r_sclk_fall <= ~w_sclk_s & r_sclk_d;
      r_ss_rise   <= w_ss_s & ~r_ss_d;
      r_ss_fall   <= ~w_ss_s & r_ss_d & r_armed;
      if (r_flush_cnt != FLUSH_DONE) begin
        r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
      end else if (w_ss_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   r_fall_pend;
  logic   w_start;

  // A frame starts on a fresh SS fall or on one that landed during DONE.
  assign w_start = r_ss_fall | r_fall_pend;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = ACTIVE;
      ACTIVE:  if (r_ss_rise) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_rx_sr;
  logic [TX_BITS-1:0]    r_tx_sr;
  logic                  r_miso;
  logic [FRAME_BITS-1:0] r_bits_out;
  logic                  r_frame_valid;
  logic                  r_frame_err;
  logic                  r_busy;

  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] w_rx_sr_nxt;
  logic [TX_BITS-1:0]    w_tx_sr_nxt;
  logic                  w_miso_nxt;
  logic [FRAME_BITS-1:0] w_bits_out_nxt;
  logic                  w_frame_valid_nxt;
  logic                  w_frame_err_nxt;
  logic                  w_busy_nxt;
  logic                  w_fall_pend_nxt;

  // Output / datapath logic. The RX shift happens before the ACTIVE->DONE
  // decision is used, so a final SCLK rise coinciding with SS rise still counts.
  always_comb begin
    w_bit_cnt_nxt     = r_bit_cnt;
    w_rx_sr_nxt       = r_rx_sr;
    w_tx_sr_nxt       = r_tx_sr;
    w_miso_nxt        = r_miso;
    w_bits_out_nxt    = r_bits_out;
    w_frame_valid_nxt = 1'b0;
    w_frame_err_nxt   = 1'b0;
    w_fall_pend_nxt   = 1'b0;
    w_busy_nxt        = (w_state_nxt == ACTIVE);
    case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_start) begin
          w_bit_cnt_nxt = '0;
          w_rx_sr_nxt   = '0;
          w_tx_sr_nxt   = i_tx_data;
          w_miso_nxt    = i_tx_data[TX_BITS-1];
        end
      end
      ACTIVE: begin
        if (r_sclk_rise) begin
          w_rx_sr_nxt = {r_rx_sr[FRAME_BITS-2:0], r_mosi_d};
          if (r_bit_cnt != CNT_OVR) begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
        if (r_sclk_fall) begin
          w_tx_sr_nxt = {r_tx_sr[TX_BITS-2:0], 1'b0};
          w_miso_nxt  = r_tx_sr[TX_BITS-2];
        end
        if (r_ss_rise) begin
          w_miso_nxt = 1'b0;
        end
      end
      DONE: begin
        w_miso_nxt      = 1'b0;
        w_fall_pend_nxt = r_ss_fall;
        if (r_bit_cnt == CNT_FULL) begin
          w_bits_out_nxt    = r_rx_sr;
          w_frame_valid_nxt = 1'b1;
        end else begin
          w_frame_err_nxt = 1'b1;
        end
      end
      default: begin
        w_miso_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt     <= '0;
      r_rx_sr       <= '0;
      r_tx_sr       <= '0;
      r_miso        <= 1'b0;
      r_bits_out    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
      r_fall_pend   <= 1'b0;
    end else begin
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_rx_sr       <= w_rx_sr_nxt;
      r_tx_sr       <= w_tx_sr_nxt;
      r_miso        <= w_miso_nxt;
      r_bits_out    <= w_bits_out_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_frame_err   <= w_frame_err_nxt;
      r_busy        <= w_busy_nxt;
      r_fall_pend   <= w_fall_pend_nxt;
    end
  end

  assign o_miso        = r_miso;
  assign o_bits_out    = r_bits_out;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_spi_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_spi_frame_rx
//   Drives SPI frames bit by bit on the pins, predicts each frame's outcome
//   (good frame / wrong length, expected bits_out and pulse cycle) into a
//   queue, and a separate monitor pops and compares whenever the DUT pulses.
//   MISO is compared against the response word before every SCLK rise.
// ----------------------------------------------------------------------------
module tb_spi_frame_rx;

  localparam int FB = 10;
  localparam int TB = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          mosi;
  logic          ss;
  logic [TB-1:0] tx_data;
  logic          miso;
  logic [FB-1:0] bits_out;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;

  spi_frame_rx #(
    .FRAME_BITS (FB),
    .TX_BITS    (TB),
    .SYNC_STAGES(S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_sclk       (sclk),
    .i_mosi       (mosi),
    .i_ss         (ss),
    .i_tx_data    (tx_data),
    .o_miso       (miso),
    .o_bits_out   (bits_out),
    .o_frame_valid(frame_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          valid;
    logic [FB-1:0] bits;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [FB-1:0] model_bits = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest predicted frame outcome.
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      check("pulse_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("frame_valid", 32'(frame_valid), 32'(mon_e.valid));
        check("frame_err", 32'(frame_err), 32'(!mon_e.valid));
        check("bits_out", 32'(bits_out), 32'(mon_e.bits));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Sends nbits bits of data (MSB first); rst_after>=0 pulses rst before that bit.
  task automatic send_frame(input logic [15:0] data, input int nbits, input logic [TB-1:0] tx,
                            input int half, input int gap, input int rst_after);
    logic aborted;
    logic exp_miso;
    aborted = 1'b0;
    tx_data = tx;
    ss      = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        model_bits = '0;
        aborted    = 1'b1;
        check("rst_bits_out", 32'(bits_out), 32'd0);
      end
      mosi = data[nbits-1-i];
      repeat (half) @(negedge clk);
      if (i == 0) check("busy_active", 32'(busy), 32'(!aborted));
      exp_miso = (aborted || i >= TB) ? 1'b0 : tx[TB-1-i];
      check($sformatf("miso_bit%0d", i), 32'(miso), 32'(exp_miso));
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    ss = 1'b1;
    if (!aborted) begin
      if (nbits == FB) model_bits = data[FB-1:0];
      q.push_back('{valid: (nbits == FB), bits: model_bits, cyc: cyc + 1 + S + 2});
    end
    repeat (gap) @(negedge clk);
    if (gap >= S + 4) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_miso", 32'(miso), 32'd0);
      check("held_bits_out", 32'(bits_out), 32'(model_bits));
    end
  endtask

  initial begin
    int sel;
    int nb;
    rst     = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    ss      = 1'b1;
    tx_data = '0;
    repeat (5) @(negedge clk);
    check("reset_bits_out", 32'(bits_out), 32'd0);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Good frame a=5 b=3 Sel=0
    send_frame(16'h014C, 10, 8'h00, 6, 10, -1);
    // Response word shifted out MSB first, then zeros
    send_frame(16'h02B7, 10, 8'hA5, 6, 10, -1);
    // Short frame after a good one: error, bits_out held
    send_frame(16'h014C, 10, 8'h3C, 6, 10, -1);
    send_frame(16'h01AA, 9, 8'hFF, 6, 10, -1);
    // Overrun frame
    send_frame(16'hFFF0, 12, 8'h81, 6, 10, -1);
    // Reset mid-frame, remainder ignored, then a full frame
    send_frame(16'h0155, 10, 8'hC3, 6, 10, 4);
    send_frame(16'h03FF, 10, 8'h5A, 6, 10, -1);
    // Back-to-back frames with minimum SS-high gap
    send_frame(16'h0123, 10, 8'h11, S + 2, S + 2, -1);
    send_frame(16'h0321, 10, 8'h22, S + 2, 12, -1);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 5));
      nb  = (sel <= 2) ? 10 : (sel == 3) ? 9 : (sel == 4) ? 11 : 12;
      send_frame(16'($urandom), nb, 8'($urandom),
                 int'($urandom_range(S + 2, S + 6)), int'($urandom_range(S + 2, 12)), -1);
    end

    for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
